// File: rtl/dac_intlv_pkg.sv
// Shared types, widths and sample-to-DAC-code helpers for the interleaved DAC transmitter.
// Also imported by the bench-side bus decoder so both ends agree on widths.
package dac_intlv_pkg;

    localparam int DAC_W = 14;
    localparam int SMP_W = 16;

    localparam logic [DAC_W-1:0] DAC_IDLE_CODE = 14'h1FFF;

    localparam logic signed [SMP_W-1:0] SAT_HI = 16'sd8191;
    localparam logic signed [SMP_W-1:0] SAT_LO = -16'sd8192;

    typedef enum logic [2:0] {
        ST_RST,
        ST_LOAD_A,
        ST_HOLD_A,
        ST_LOAD_B,
        ST_HOLD_B
    } dac_state_e;

    function automatic logic signed [DAC_W-1:0] sat14(input logic signed [SMP_W-1:0] x);
        logic signed [DAC_W-1:0] v;
        if (x > SAT_HI) begin
            v = 14'sh1FFF;
        end else if (x < SAT_LO) begin
            v = 14'sh2000;
        end else begin
            v = x[DAC_W-1:0];
        end
        return v;
    endfunction

    // The DAC wants the magnitude bits inverted while the sign bit passes straight through.
    function automatic logic [DAC_W-1:0] dac_encode(input logic signed [DAC_W-1:0] v);
        return {v[DAC_W-1], ~v[DAC_W-2:0]};
    endfunction

endpackage

// File: rtl/dac_intlv_tx_if.sv
// Sample stream in (valid/ready pairs) and the interleaved DAC pin bus out.
// master = sample source / DAC side, slave = the transmitter.
interface dac_intlv_tx_if;

    logic signed [dac_intlv_pkg::SMP_W-1:0] s_dat_a_i;
    logic signed [dac_intlv_pkg::SMP_W-1:0] s_dat_b_i;
    logic                                   s_valid_i;
    logic                                   s_ready_o;
    logic        [dac_intlv_pkg::DAC_W-1:0] dac_dat_o;
    logic                                   dac_wrt_o;
    logic                                   dac_sel_o;
    logic                                   dac_rst_o;

    modport master (
        output s_dat_a_i,
        output s_dat_b_i,
        output s_valid_i,
        input  s_ready_o,
        input  dac_dat_o,
        input  dac_wrt_o,
        input  dac_sel_o,
        input  dac_rst_o
    );

    modport slave (
        input  s_dat_a_i,
        input  s_dat_b_i,
        input  s_valid_i,
        output s_ready_o,
        output dac_dat_o,
        output dac_wrt_o,
        output dac_sel_o,
        output dac_rst_o
    );

endinterface

// File: rtl/dac_intlv_fifo2.sv
// Two-entry FIFO with first-word-fall-through read data and synchronous clear.
// A push while full is taken only when a pop happens on the same edge.
module dac_intlv_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/dac_intlv_tx.sv
// Serialises A/B sample pairs onto a single 14-bit DAC bus, one pair per 4 clocks.
// Optional feature macro: DAC_TX_UNDERRUN_CNT_EN adds a saturating underrun counter output.
module dac_intlv_tx
    import dac_intlv_pkg::*;
#(
    parameter int unsigned RST_HOLD = 4
) (
    input  logic          dac_clk_i,
    input  logic          dac_rst_i,
    dac_intlv_tx_if.slave bus,
    output logic          underrun_o
`ifdef DAC_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]   underrun_cnt_o
`endif
);

    localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);

    dac_state_e state;
    dac_state_e nxt;
    logic [3:0] hold_cnt;
    logic       pop;
    logic       push;
    logic       fifo_full;
    logic       fifo_empty;

    logic [2*SMP_W-1:0]      fifo_rdata;
    logic signed [SMP_W-1:0] smp_a_p0;
    logic signed [SMP_W-1:0] smp_b_p0;
    logic [DAC_W-1:0]        code_a_p0;
    logic [DAC_W-1:0]        code_b_p0;

    logic [DAC_W-1:0] dat_p1;
    logic [DAC_W-1:0] code_b_p1;
    logic             wrt_p1;
    logic             sel_p1;
    logic             rst_p1;
    logic             und_p1;

    // Ready also opens on a pop edge so a full buffer can take a new pair while one leaves.
    assign bus.s_ready_o = ~dac_rst_i & (~fifo_full | pop);
    assign push          = bus.s_valid_i & bus.s_ready_o;

    dac_intlv_fifo2 #(
        .W(2 * SMP_W)
    ) u_fifo (
        .clk  (dac_clk_i),
        .clr  (dac_rst_i),
        .push (push),
        .pop  (pop),
        .wdata({bus.s_dat_a_i, bus.s_dat_b_i}),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Stage p0: head-of-buffer pair, clamped and encoded combinationally.
    assign smp_a_p0  = fifo_rdata[2*SMP_W-1:SMP_W];
    assign smp_b_p0  = fifo_rdata[SMP_W-1:0];
    assign code_a_p0 = dac_encode(sat14(smp_a_p0));
    assign code_b_p0 = dac_encode(sat14(smp_b_p0));

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state    <= ST_RST;
            hold_cnt <= '0;
        end else begin
            state <= nxt;
            if (state == ST_RST && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        nxt = state;
        pop = 1'b0;
        unique case (state)
            ST_RST: begin
                if (hold_cnt == HOLD_LAST) begin
                    nxt = ST_LOAD_A;
                    pop = 1'b1;
                end
            end
            ST_LOAD_A: nxt = ST_HOLD_A;
            ST_HOLD_A: nxt = ST_LOAD_B;
            ST_LOAD_B: nxt = ST_HOLD_B;
            ST_HOLD_B: begin
                nxt = ST_LOAD_A;
                pop = 1'b1;
            end
            default: nxt = ST_RST;
        endcase
        if (dac_rst_i) begin
            nxt = ST_RST;
            pop = 1'b0;
        end
    end

    // Stage p1: registered pin outputs, driven from the state being entered.
    // B is captured with A at pop time so later pushes cannot disturb the pair in flight.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            dat_p1    <= DAC_IDLE_CODE;
            code_b_p1 <= DAC_IDLE_CODE;
            wrt_p1    <= 1'b1;
            sel_p1    <= 1'b0;
            rst_p1    <= 1'b1;
            und_p1    <= 1'b0;
        end else begin
            wrt_p1 <= ~(nxt == ST_LOAD_A || nxt == ST_LOAD_B);
            sel_p1 <= (nxt == ST_LOAD_B || nxt == ST_HOLD_B);
            rst_p1 <= (nxt == ST_RST);
            und_p1 <= pop & fifo_empty;
            if (pop) begin
                dat_p1    <= fifo_empty ? DAC_IDLE_CODE : code_a_p0;
                code_b_p1 <= fifo_empty ? DAC_IDLE_CODE : code_b_p0;
            end else if (nxt == ST_LOAD_B) begin
                dat_p1 <= code_b_p1;
            end
        end
    end

    assign bus.dac_dat_o = dat_p1;
    assign bus.dac_wrt_o = wrt_p1;
    assign bus.dac_sel_o = sel_p1;
    assign bus.dac_rst_o = rst_p1;
    assign underrun_o    = und_p1;

`ifdef DAC_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt_p1;

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            ucnt_p1 <= '0;
        end else if (pop && fifo_empty && ucnt_p1 != 16'hFFFF) begin
            ucnt_p1 <= ucnt_p1 + 16'd1;
        end
    end

    assign underrun_cnt_o = ucnt_p1;
`endif

endmodule

// File: tb/tb_dac_intlv_tx.sv
// Directed bench for dac_intlv_tx: drives sample pairs and decodes the DAC bus back to values.
// Underrun-counter checks are compiled in when DAC_TX_UNDERRUN_CNT_EN is defined.
module tb_dac_intlv_tx;
    import dac_intlv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic und;

    always #5 clk = ~clk;

    dac_intlv_tx_if bus ();

`ifdef DAC_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt;
    logic [15:0] obs_ucnt;
`endif

    dac_intlv_tx #(
        .RST_HOLD(4)
    ) dut (
        .dac_clk_i (clk),
        .dac_rst_i (rst),
        .bus       (bus),
        .underrun_o(und)
`ifdef DAC_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o(ucnt)
`endif
    );

    typedef struct {
        int a;
        int b;
    } pair_t;

    pair_t pend[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    rst_req = 1'b1;
    bit    acc_pending = 1'b0;

    logic [13:0] obs_a, obs_ha, obs_b, obs_hb;
    logic [3:0]  obs_wrt, obs_sel, obs_und, obs_rdy;

    // Bus receiver model: code = 8191 - v over the whole 14-bit range.
    function automatic logic [13:0] exp_code(input int v);
        return 14'(8191 - v);
    endfunction

    function automatic int dec(input logic [13:0] c);
        return 8191 - int'(c);
    endfunction

    // One clock: retire last accepted pair, drive inputs, then sample away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (acc_pending) pend.delete(0);
        rst = rst_req;
        bus.s_valid_i = (pend.size() > 0);
        if (pend.size() > 0) begin
            bus.s_dat_a_i = 16'(pend[0].a);
            bus.s_dat_b_i = 16'(pend[0].b);
        end
        #1;
        acc_pending = bus.s_valid_i && bus.s_ready_o;
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        repeat (4) step();
    endtask

    task automatic run_slot();
        for (int i = 0; i < 4; i++) begin
            step();
            obs_wrt[i] = bus.dac_wrt_o;
            obs_sel[i] = bus.dac_sel_o;
            obs_und[i] = und;
            obs_rdy[i] = bus.s_ready_o;
            case (i)
                0: obs_a = bus.dac_dat_o;
                1: obs_ha = bus.dac_dat_o;
                2: obs_b = bus.dac_dat_o;
                default: obs_hb = bus.dac_dat_o;
            endcase
`ifdef DAC_TX_UNDERRUN_CNT_EN
            if (i == 0) obs_ucnt = ucnt;
`endif
        end
    endtask

    task automatic test_reset();
        rst_req = 1'b1;
        pend.push_back('{100, 200});
        step();
        step();
        n_cmp++;
        if ({bus.dac_dat_o, bus.dac_wrt_o, bus.dac_sel_o, bus.dac_rst_o} !== {14'h1FFF, 3'b101}) begin
            n_bad++;
            $display("FAIL reset_pins: dat/wrt/sel/rst got %h/%b/%b/%b want 1fff/1/0/1",
                     bus.dac_dat_o, bus.dac_wrt_o, bus.dac_sel_o, bus.dac_rst_o);
        end
        n_cmp++;
        if ({bus.s_ready_o, und} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ready_und: got %b%b want 00", bus.s_ready_o, und);
        end
`ifdef DAC_TX_UNDERRUN_CNT_EN
        n_cmp++;
        if (ucnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_ucnt: got %0d want 0", ucnt);
        end
`endif
        pend.delete();
    endtask

    task automatic test_reset_release();
        rst_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++;
            if ({bus.dac_rst_o, bus.dac_wrt_o, bus.dac_dat_o} !== {2'b11, 14'h1FFF}) begin
                n_bad++;
                $display("FAIL release_hold[%0d]: rst/wrt/dat got %b/%b/%h want 1/1/1fff",
                         c, bus.dac_rst_o, bus.dac_wrt_o, bus.dac_dat_o);
            end
            if (c == 0) begin
                n_cmp++;
                if (bus.s_ready_o !== 1'b1) begin
                    n_bad++;
                    $display("FAIL release_ready: got %b want 1", bus.s_ready_o);
                end
            end
        end
        step();
        n_cmp++;
        if ({bus.dac_rst_o, bus.dac_wrt_o, bus.dac_sel_o, und, bus.dac_dat_o} !== {4'b0001, 14'h1FFF}) begin
            n_bad++;
            $display("FAIL release_load_a: rst/wrt/sel/und/dat got %b/%b/%b/%b/%h want 0/0/0/1/1fff",
                     bus.dac_rst_o, bus.dac_wrt_o, bus.dac_sel_o, und, bus.dac_dat_o);
        end
`ifdef DAC_TX_UNDERRUN_CNT_EN
        n_cmp++;
        if (ucnt !== 16'd1) begin
            n_bad++;
            $display("FAIL release_ucnt: got %0d want 1", ucnt);
        end
`endif
        step();
        n_cmp++;
        if ({und, bus.dac_wrt_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL release_hold_a: und/wrt got %b/%b want 0/1", und, bus.dac_wrt_o);
        end
    endtask

    task automatic test_encoding();
        int ia[3] = '{0, 8191, 20000};
        int ib[3] = '{-1, -8192, -30000};
        int ea[3] = '{0, 8191, 8191};
        int eb[3] = '{-1, -8192, -8192};
        for (int k = 0; k < 3; k++) pend.push_back('{ia[k], ib[k]});
        do_reset();
        for (int k = 0; k < 3; k++) begin
            run_slot();
            n_cmp++;
            if ({obs_a, obs_ha, obs_b, obs_hb} !== {exp_code(ea[k]), exp_code(ea[k]), exp_code(eb[k]), exp_code(eb[k])}) begin
                n_bad++;
                $display("FAIL enc_codes[%0d]: got %h %h %h %h want %h %h %h %h", k, obs_a, obs_ha, obs_b, obs_hb,
                         exp_code(ea[k]), exp_code(ea[k]), exp_code(eb[k]), exp_code(eb[k]));
            end
            n_cmp++;
            if (dec(obs_a) != ea[k] || dec(obs_b) != eb[k]) begin
                n_bad++;
                $display("FAIL enc_decode[%0d]: got %0d/%0d want %0d/%0d", k, dec(obs_a), dec(obs_b), ea[k], eb[k]);
            end
            n_cmp++;
            if ({obs_wrt, obs_sel, obs_und} !== {4'b1010, 4'b1100, 4'b0000}) begin
                n_bad++;
                $display("FAIL enc_strobes[%0d]: wrt/sel/und got %b/%b/%b want 1010/1100/0000", k, obs_wrt, obs_sel, obs_und);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rdy_exp;
        for (int k = 0; k < 10; k++) pend.push_back('{1000 * k - 4000, 37 - 900 * k});
        do_reset();
        for (int k = 0; k < 10; k++) begin
            rdy_exp = (k < 8) ? 4'b1000 : 4'b1111;
            run_slot();
            n_cmp++;
            if (dec(obs_a) != 1000 * k - 4000 || dec(obs_b) != 37 - 900 * k) begin
                n_bad++;
                $display("FAIL b2b_data[%0d]: got %0d/%0d want %0d/%0d", k, dec(obs_a), dec(obs_b), 1000 * k - 4000, 37 - 900 * k);
            end
            n_cmp++;
            if ({obs_rdy, obs_und, obs_wrt} !== {rdy_exp, 4'b0000, 4'b1010}) begin
                n_bad++;
                $display("FAIL b2b_ctrl[%0d]: rdy/und/wrt got %b/%b/%b want %b/0000/1010", k, obs_rdy, obs_und, obs_wrt, rdy_exp);
            end
        end
    endtask

    task automatic test_underrun();
        int ea[5] = '{100, -5000, 8191, 0, 0};
        int eb[5] = '{-100, 5000, -8192, 0, 0};
        pend.push_back('{100, -100});
        pend.push_back('{-5000, 5000});
        pend.push_back('{32767, -32768});
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_slot();
            n_cmp++;
            if ({obs_a, obs_b} !== {exp_code(ea[k]), exp_code(eb[k])}) begin
                n_bad++;
                $display("FAIL und_data[%0d]: got %h/%h want %h/%h", k, obs_a, obs_b, exp_code(ea[k]), exp_code(eb[k]));
            end
            n_cmp++;
            if (obs_und !== ((k >= 3) ? 4'b0001 : 4'b0000)) begin
                n_bad++;
                $display("FAIL und_pulse[%0d]: got %b want %b", k, obs_und, (k >= 3) ? 4'b0001 : 4'b0000);
            end
`ifdef DAC_TX_UNDERRUN_CNT_EN
            n_cmp++;
            if (obs_ucnt !== ((k >= 3) ? 16'(k - 2) : 16'd0)) begin
                n_bad++;
                $display("FAIL und_count[%0d]: got %0d want %0d", k, obs_ucnt, (k >= 3) ? k - 2 : 0);
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 1; k <= 4; k++) pend.push_back('{k * 7, -k * 7});
        do_reset();
        step();
        n_cmp++;
        if (bus.dac_dat_o !== exp_code(7)) begin
            n_bad++;
            $display("FAIL mid_first_a: got %h want %h", bus.dac_dat_o, exp_code(7));
        end
        step();
        rst_req = 1'b1;
        step();
        step();
        n_cmp++;
        if ({bus.dac_dat_o, bus.dac_wrt_o, bus.dac_sel_o, bus.dac_rst_o, bus.s_ready_o, und} !== {14'h1FFF, 5'b10100}) begin
            n_bad++;
            $display("FAIL mid_reset_vals: dat/wrt/sel/rst/rdy/und got %h/%b/%b/%b/%b/%b want 1fff/1/0/1/0/0",
                     bus.dac_dat_o, bus.dac_wrt_o, bus.dac_sel_o, bus.dac_rst_o, bus.s_ready_o, und);
        end
`ifdef DAC_TX_UNDERRUN_CNT_EN
        n_cmp++;
        if (ucnt !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_reset_ucnt: got %0d want 0", ucnt);
        end
`endif
        pend.delete();
        rst_req = 1'b0;
        repeat (4) step();
        run_slot();
        n_cmp++;
        if ({obs_a, obs_b, obs_und} !== {14'h1FFF, 14'h1FFF, 4'b0001}) begin
            n_bad++;
            $display("FAIL mid_flushed: a/b/und got %h/%h/%b want 1fff/1fff/0001", obs_a, obs_b, obs_und);
        end
    endtask

    task automatic test_simul_push_pop();
        logic [3:0] rdy_exp[5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1111, 4'b1111};
        for (int k = 1; k <= 5; k++) pend.push_back('{k * 11, -k * 11});
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_slot();
            n_cmp++;
            if (dec(obs_a) != (k + 1) * 11 || dec(obs_b) != -(k + 1) * 11) begin
                n_bad++;
                $display("FAIL spp_order[%0d]: got %0d/%0d want %0d/%0d", k, dec(obs_a), dec(obs_b), (k + 1) * 11, -(k + 1) * 11);
            end
            n_cmp++;
            if ({obs_rdy, obs_und} !== {rdy_exp[k], 4'b0000}) begin
                n_bad++;
                $display("FAIL spp_ready[%0d]: rdy/und got %b/%b want %b/0000", k, obs_rdy, obs_und, rdy_exp[k]);
            end
        end
        run_slot();
        n_cmp++;
        if ({obs_a, obs_und} !== {14'h1FFF, 4'b0001}) begin
            n_bad++;
            $display("FAIL spp_drain: a/und got %h/%b want 1fff/0001", obs_a, obs_und);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.s_valid_i = 1'b0;
        bus.s_dat_a_i = '0;
        bus.s_dat_b_i = '0;
        test_reset();
        test_reset_release();
        test_encoding();
        test_back_to_back();
        test_underrun();
        test_mid_reset();
        test_simul_push_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dac_intlv_tx.md
# dac_intlv_tx

Transmit side of the interleaved dual-channel DAC bus: accepts channel A/B sample pairs over a valid/ready stream and serialises them onto one 14-bit data bus. The bus carries an active-low write strobe and a channel select, in the inverted-magnitude code the DAC expects. It sits between the signal generator output stage and the DAC pins. The bus-model receiver in the testbench decodes its output back into two channels.

## Interface
- `RST_HOLD`, 4: cycles `dac_rst_o` stays high after `dac_rst_i` deasserts (1..15).
- `dac_clk_i`  in  1  DAC clock. One pair is emitted every 4 cycles.
- `dac_rst_i`  in  1  Reset. Synchronous and active-high.
- `s_dat_a_i`  in  16  Channel A sample, signed.
- `s_dat_b_i`  in  16  Channel B sample, signed.
- `s_valid_i`  in  1  Pair valid.
- `s_ready_o`  out  1  Buffer not full.
- `dac_dat_o`  out  14  Encoded DAC data.
- `dac_wrt_o`  out  1  Write strobe. Active-low.
- `dac_sel_o`  out  1  Channel select: 0 = A, 1 = B.
- `dac_rst_o`  out  1  DAC reset.
- `underrun_o`  out  1  One-cycle pulse when a pair slot finds the buffer empty.
- `underrun_cnt_o`  out  16  Present only with `DAC_TX_UNDERRUN_CNT_EN`.

## Operation
- **Input buffer.** 2-entry FIFO.
  - Push on `s_valid_i & s_ready_o`.
  - `s_ready_o` = not full. It is 0 while `dac_rst_i` is high.
  - Push and pop in the same cycle are both allowed when full. Occupancy is unchanged.
- **Saturation.** Each sample is clamped to [-8192, 8191], giving a 14-bit value `v`.
- **Encoding.** `dac_dat_o = {v[13], ~v[12:0]}`. Examples:
  - 0 -> 14'h1FFF
  - 8191 -> 14'h0000
  - -8192 -> 14'h3FFF
  - -1 -> 14'h2000
  - 20000 -> 14'h0000 (clamped)
- **FSM states.** RST, LOAD_A, HOLD_A, LOAD_B, HOLD_B.
  - RST: stays until the hold counter expires, then goes to LOAD_A.
  - LOAD_A -> HOLD_A -> LOAD_B -> HOLD_B -> LOAD_A, unconditionally.
- **Pop.** A pair is popped on the edge HOLD_B -> LOAD_A, and on the edge RST -> LOAD_A.
- **Underrun.** If the buffer is empty at a pop edge:
  - The slot emits the code for 0 on both channels (14'h1FFF).
  - `underrun_o` pulses for the LOAD_A cycle.
- **Per-state outputs:**
  - LOAD_A: `dac_sel_o`=0, `dac_wrt_o`=0, data = encoded A.
  - HOLD_A: `dac_sel_o`=0, `dac_wrt_o`=1, data held.
  - LOAD_B: `dac_sel_o`=1, `dac_wrt_o`=0, data = encoded B.
  - HOLD_B: `dac_sel_o`=1, `dac_wrt_o`=1, data held.
- **Channel B latch.** B is latched at pop time together with A. Later pushes never alter a pair already in flight.

## Timing
- **Reset values:**
  - `dac_dat_o`=14'h1FFF
  - `dac_wrt_o`=1
  - `dac_sel_o`=0
  - `dac_rst_o`=1
  - `s_ready_o`=0
  - `underrun_o`=0
  - `underrun_cnt_o`=0
  - FIFO empty, FSM in RST.
- **Reset release.** After `dac_rst_i` falls, `dac_rst_o` stays high for exactly `RST_HOLD` cycles. It falls on the same edge that enters LOAD_A.
- **Ready.** `s_ready_o` rises on the first cycle after `dac_rst_i` falls.
- **Outputs are registered.**
  - Latency from a push edge into an empty FIFO to the data on `dac_dat_o` is 1 cycle at minimum, when the push lands in HOLD_B.
  - It is 4 cycles at maximum.
- **Throughput.** One pair per 4 cycles. `dac_wrt_o` duty cycle is 50%. `dac_sel_o` toggles every 2 cycles.
- **Reset mid-operation.** `dac_rst_i` asserted in any state:
  - The next edge forces all reset values.
  - FIFO contents are discarded.
  - Any pair in flight is dropped.

## Configuration
- `DAC_TX_UNDERRUN_CNT_EN` defined:
  - `underrun_cnt_o` exists.
  - It increments on each `underrun_o` pulse and saturates at 16'hFFFF.
  - It is cleared only by `dac_rst_i`.
  - Counting also runs during the first pop after reset if the FIFO is empty.
- Macro undefined: the port and the counter are absent, and `underrun_o` is unchanged.

## Structure
- **Package `dac_intlv_pkg`:**
  - FSM state enum.
  - `DAC_W`=14 and `SMP_W`=16 constants.
  - `DAC_IDLE_CODE`=14'h1FFF.
  - Pure functions `sat14()` and `dac_encode()`.
  - The testbench decoder imports the same package.
- **Sub-module `dac_intlv_fifo2`:** 2-entry, 32-bit-wide FIFO with push, pop, full, empty and synchronous clear.

## Test plan
- **Reset release:** `RST_HOLD`=4, `dac_rst_i` released at cycle 0 -> `dac_rst_o` high through cycle 3, LOAD_A at cycle 4, `dac_dat_o`=14'h1FFF, `underrun_o`=1 at cycle 4.
- **Encoding:** pairs (0,-1), (8191,-8192), (20000,-30000) -> A/B codes 1FFF/2000, 0000/3FFF, 0000/3FFF. Each is written with `dac_wrt_o`=0, with `dac_sel_o`=0 for A and 1 for B. The receiver model returns the clamped values.
- **Back-pressure:** `s_valid_i` held high with 10 distinct pairs -> `s_ready_o` drops when the FIFO holds 2 entries. All 10 pairs are emitted in order at one per 4 cycles, with no underrun.
- **Underrun:** pushes stop after 3 pairs -> the 4th slot emits 1FFF/1FFF, `underrun_o` pulses once per empty slot, and `underrun_cnt_o` counts 1, 2, … (with the macro).
- **Mid-operation reset:** reset asserted in LOAD_B with a full FIFO -> next cycle shows all reset values. After release, the first slot is an underrun (old data flushed).
- **Simultaneous push/pop:** FIFO full, push on the HOLD_B -> LOAD_A edge -> accepted, occupancy stays 2, ordering preserved.
